// File: rtl/tstate_pkg.sv
// ============================================================================
// Module  : tstate_pkg
// Brief   : Shared widths and state encoding for the T-state controller.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package tstate_pkg;

    localparam int c_t_width      = 3;
    localparam int c_onehot_width = 8;
    localparam int c_count_width  = 16;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_ENDING  = 2'd1,
        ST_HALTED  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/tstate_decode.sv
// ============================================================================
// Module  : tstate_decode
// Brief   : Registered one-hot decode of the current T-state.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tstate_decode
    import tstate_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [c_t_width-1:0]      t,
    output logic [c_onehot_width-1:0] onehot
);

    logic [c_onehot_width-1:0] r_onehot;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_onehot <= c_onehot_width'(1);
        end else begin
            r_onehot <= c_onehot_width'(1) << t;
        end
    end

    assign onehot = r_onehot;

endmodule

`default_nettype wire

// File: rtl/tstate_control.sv
// ============================================================================
// Module  : tstate_control
// Brief   : Instruction-boundary controller for an external T-state counter:
//           end-of-instruction clear pulse, halt at boundary, instruction count.
//           Optional T-sequence checker enabled by macro TSTATE_SEQCHECK_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tstate_control
    import tstate_pkg::*;
#(
    parameter int TMAX = 7
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [c_t_width-1:0]      T,
    input  logic                      ucode_end,
    input  logic                      halt_req,
    output logic                      reset2_bar,
    output logic [c_onehot_width-1:0] t_onehot,
    output logic                      fetch,
    output logic                      halted,
    output logic [c_count_width-1:0]  instr_count,
    output logic                      seq_err
);

    state_t                     r_state;
    state_t                     w_next_state;
    logic                       w_end;
    logic                       w_count_inc;
    logic                       w_release;
    logic                       r_reset2_bar;
    logic [c_count_width-1:0]   r_instr_count;

    // T0/T1 are fetch cycles, so ucode_end only counts from T2 onward
    assign w_end = ((ucode_end && (T >= c_t_width'(2))) || (T == c_t_width'(TMAX)));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_end) begin
                    w_next_state = ST_ENDING;
                end
            end
            ST_ENDING: begin
                if (T == '0) begin
                    w_next_state = halt_req ? ST_HALTED : ST_RUN;
                end
            end
            ST_HALTED: begin
                if (!halt_req) begin
                    w_next_state = ST_RUN;
                end
            end
            default: w_next_state = ST_RUN;
        endcase
    end

    always_comb begin
        w_count_inc = (r_state == ST_ENDING) && (T == '0);
        w_release   = (w_next_state == ST_RUN);
        halted      = (r_state == ST_HALTED);
    end

    // The counter samples reset2_bar on the falling edge, so it is registered
    // here to stay stable for the whole clk period following each decision.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_reset2_bar  <= 1'b0;
            r_instr_count <= '0;
        end else begin
            r_reset2_bar <= w_release;
            if (w_count_inc) begin
                r_instr_count <= r_instr_count + c_count_width'(1);
            end
        end
    end

    assign reset2_bar  = r_reset2_bar;
    assign instr_count = r_instr_count;

    tstate_decode u_decode (
        .clk    (clk),
        .rst    (reset),
        .t      (T),
        .onehot (t_onehot)
    );

    assign fetch = t_onehot[0] | t_onehot[1];

`ifdef TSTATE_SEQCHECK_EN
    logic [c_t_width-1:0] r_exp_t;
    logic                 r_chk_armed;
    logic                 r_seq_err;

    // Expected T follows the counter: +1 while released, 0 while held clear
    always_ff @(posedge clk) begin
        if (reset) begin
            r_exp_t     <= '0;
            r_chk_armed <= 1'b0;
            r_seq_err   <= 1'b0;
        end else begin
            r_chk_armed <= 1'b1;
            r_exp_t     <= w_release ? (T + c_t_width'(1)) : '0;
            if (r_chk_armed && (T != r_exp_t)) begin
                r_seq_err <= 1'b1;
            end
        end
    end

    assign seq_err = r_seq_err;
`else
    assign seq_err = 1'b0;
`endif

endmodule

`default_nettype wire
